// File: rtl/swd_transaction.sv
// SWD transaction sequencer: runs one DP/AP access through the bit engine
// (header, ACK, data, trailing idle) with WAIT retry and request timeout.
module swd_transaction #(
    parameter int unsigned MAX_RETRIES = 8,
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned REQ_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  speedDivisor,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_apndp,
    input  logic        cmd_rnw,
    input  logic [1:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_perr,
    output logic        rsp_timeout,
    output logic [4:0]  bits,
    output logic        useParity,
    output logic        txReq,
    output logic        rxReq,
    output logic [31:0] dataToSWD,
    input  logic [31:0] dataFromSWD,
    input  logic        parityGood,
    input  logic        busy
);

    localparam int unsigned CW = 16;
    localparam int unsigned RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_ACK, ST_RD, ST_WR, ST_TRAIL, ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_GAP, PH_REQ, PH_RUN
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retries_q, retries_d;

    logic        apndp_q, apndp_d;
    logic        rnw_q, rnw_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [1:0]  status_q, status_d;
    logic [2:0]  ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        perr_q, perr_d;
    logic        timeout_q, timeout_d;

    logic [1:0]  rsp_status_q;
    logic [2:0]  rsp_ack_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_perr_q;
    logic        rsp_timeout_q;

    logic          ph_tx;
    logic          in_phase;
    logic          load_rsp;
    logic          hdr_par;
    logic [CW-1:0] gap_last;
    logic [CW-1:0] to_last;

    // Engine needs req low for 4*(div+1)+4 clocks; counter runs 0..gap-1.
    assign gap_last = {{(CW-8){1'b0}}, speedDivisor, 2'b00} + CW'(7);
    assign to_last  = CW'(REQ_TIMEOUT - 1);
    assign hdr_par  = apndp_q ^ rnw_q ^ addr_q[0] ^ addr_q[1];
    assign in_phase = (state_q != ST_IDLE) && (state_q != ST_DONE);

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_DONE);
    assign rsp_status  = rsp_status_q;
    assign rsp_ack     = rsp_ack_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_perr    = rsp_perr_q;
    assign rsp_timeout = rsp_timeout_q;

    // Engine-facing setup depends only on the main state, so it cannot move while a req is high.
    always_comb begin
        ph_tx     = 1'b1;
        bits      = '0;
        useParity = 1'b0;
        dataToSWD = '0;
        case (state_q)
            ST_HDR: begin
                bits      = 5'd7;
                dataToSWD = {24'h0, 1'b1, 1'b0, hdr_par, addr_q[1], addr_q[0], rnw_q, apndp_q, 1'b1};
            end
            ST_ACK: begin
                ph_tx = 1'b0;
                bits  = 5'd2;
            end
            ST_RD: begin
                ph_tx     = 1'b0;
                bits      = 5'd31;
                useParity = 1'b1;
            end
            ST_WR: begin
                bits      = 5'd31;
                useParity = 1'b1;
                dataToSWD = wdata_q;
            end
            ST_TRAIL: bits = 5'(IDLE_CYCLES - 1);
            default: ;
        endcase
        txReq = in_phase && (phase_q == PH_REQ) && ph_tx;
        rxReq = in_phase && (phase_q == PH_REQ) && !ph_tx;
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        apndp_d   = apndp_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        status_d  = status_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        perr_d    = perr_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d   = ST_HDR;
                    phase_d   = PH_GAP;
                    cnt_d     = '0;
                    retries_d = '0;
                    apndp_d   = cmd_apndp;
                    rnw_d     = cmd_rnw;
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    status_d  = '0;
                    ack_d     = '0;
                    rdata_d   = '0;
                    perr_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                case (phase_q)
                    PH_GAP: begin
                        if (cnt_q == gap_last) begin
                            phase_d = PH_REQ;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    PH_REQ: begin
                        if (busy) begin
                            phase_d = PH_RUN;
                        end else if (cnt_q == to_last) begin
                            timeout_d = 1'b1;
                            status_d  = 2'd3;
                            state_d   = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        if (!busy) begin
                            phase_d = PH_GAP;
                            cnt_d   = '0;
                            case (state_q)
                                ST_HDR: state_d = ST_ACK;
                                ST_ACK: begin
                                    ack_d = dataFromSWD[2:0];
                                    case (dataFromSWD[2:0])
                                        3'b001: state_d = rnw_q ? ST_RD : ST_WR;
                                        3'b010: begin
                                            if (retries_q < RW'(MAX_RETRIES)) begin
                                                retries_d = retries_q + RW'(1);
                                                state_d   = ST_HDR;
                                            end else begin
                                                status_d = 2'd1;
                                                state_d  = ST_DONE;
                                            end
                                        end
                                        3'b100: begin
                                            status_d = 2'd2;
                                            state_d  = ST_DONE;
                                        end
                                        default: begin
                                            status_d = 2'd3;
                                            state_d  = ST_DONE;
                                        end
                                    endcase
                                end
                                ST_RD: begin
                                    rdata_d  = dataFromSWD;
                                    perr_d   = !parityGood;
                                    status_d = parityGood ? 2'd0 : 2'd3;
                                    state_d  = (parityGood && IDLE_CYCLES != 0) ? ST_TRAIL : ST_DONE;
                                end
                                ST_WR: begin
                                    status_d = 2'd0;
                                    state_d  = (IDLE_CYCLES != 0) ? ST_TRAIL : ST_DONE;
                                end
                                default: state_d = ST_DONE;
                            endcase
                        end
                    end
                endcase
            end
        endcase
    end

    assign load_rsp = (state_d == ST_DONE) && (state_q != ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            phase_q       <= PH_GAP;
            cnt_q         <= '0;
            retries_q     <= '0;
            apndp_q       <= 1'b0;
            rnw_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            status_q      <= '0;
            ack_q         <= '0;
            rdata_q       <= '0;
            perr_q        <= 1'b0;
            timeout_q     <= 1'b0;
            rsp_status_q  <= '0;
            rsp_ack_q     <= '0;
            rsp_rdata_q   <= '0;
            rsp_perr_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            apndp_q   <= apndp_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            status_q  <= status_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            perr_q    <= perr_d;
            timeout_q <= timeout_d;
            if (load_rsp) begin
                rsp_status_q  <= status_d;
                rsp_ack_q     <= ack_d;
                rsp_rdata_q   <= rdata_d;
                rsp_perr_q    <= perr_d;
                rsp_timeout_q <= timeout_d;
            end
        end
    end

endmodule
